// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (AND, OR, ADD, SLT with a/b invert).
// Stage 1 registers conditioned operands plus per-bit generate/propagate;
// stage 2 resolves the carry chain and registers result and flags.
// Optional macro ALU_PIPE_FLAGS_EN: when defined, zero/cout/overflow are
// computed and registered; otherwise they are tied to 0.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    // Stage 1 state
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [WIDTH-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    logic [1:0]       r_s1_op;

    // Stage 2 state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;

    logic             w_s2_en;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
`ifdef ALU_PIPE_FLAGS_EN
    logic             w_cout;
`endif

    // Stage 2 may take new data when empty or when its result is consumed;
    // stage 1 may load whenever it is empty or stage 2 is moving.
    assign w_s2_en  = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_en;

    assign w_a = a ^ {WIDTH{op[3]}};
    assign w_b = b ^ {WIDTH{op[2]}};

    // Stage 1: capture conditioned operands and generate/propagate terms
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
            r_s1_op    <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a   <= w_a;
                r_s1_b   <= w_b;
                r_s1_cin <= op[2];
                r_s1_g   <= w_a & w_b;
                r_s1_p   <= w_a | w_b;
                r_s1_op  <= op[1:0];
            end
        end
    end

    // Carry resolution from registered generate/propagate, sum, result mux
    always_comb begin
        logic [WIDTH:0] w_c;
        w_c    = '0;
        w_c[0] = r_s1_cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_c[i+1] = r_s1_g[i] | (r_s1_p[i] & w_c[i]);
        end
        w_sum = r_s1_a ^ r_s1_b ^ w_c[WIDTH-1:0];
        w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];
`ifdef ALU_PIPE_FLAGS_EN
        w_cout = w_c[WIDTH];
`endif
        w_res = '0;
        unique case (r_s1_op)
            2'b00: w_res = r_s1_g;
            2'b01: w_res = r_s1_p;
            2'b10: w_res = w_sum;
            2'b11: w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
        endcase
    end

    // Stage 2: register result; hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic r_zero;
    logic r_cout;
    logic r_ovf;

    // Stage 2 flag registers, updated alongside the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_en && r_s1_valid) begin
            r_zero <= (w_res == '0);
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

    assign zero     = r_zero;
    assign cout     = r_cout;
    assign overflow = r_ovf;
`else
    assign zero     = 1'b0;
    assign cout     = 1'b0;
    assign overflow = 1'b0;
`endif

    assign out_valid = r_s2_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed table-driven checks of alu_pipe (WIDTH=32 and 8),
// plus hand-written streaming, backpressure and mid-flight reset sequences.
module tb_alu_pipe;

`ifdef ALU_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  op32;
    logic        z32, c32, v32;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;
    logic        z8, c8, v8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .op(op32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .result(res32), .zero(z32), .cout(c32), .overflow(v32)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(res8), .zero(z8), .cout(c8), .overflow(v8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation through the 32-bit pipe: accept, one empty cycle, then result
    task automatic run_vec(input int i);
        a32 = vecs[i].a; b32 = vecs[i].b; op32 = vecs[i].op;
        in_valid32 = 1'b1;
        check($sformatf("v%0d_in_ready", i), 64'(in_ready32), 64'd1);
        tick();
        in_valid32 = 1'b0;
        check($sformatf("v%0d_lat1_valid", i), 64'(out_valid32), 64'd0);
        tick();
        check($sformatf("v%0d_out_valid", i), 64'(out_valid32), 64'd1);
        check($sformatf("v%0d_result", i), 64'(res32), 64'(vecs[i].res));
        check($sformatf("v%0d_zero", i), 64'(z32), 64'(vecs[i].z & FLAGS));
        check($sformatf("v%0d_cout", i), 64'(c32), 64'(vecs[i].c & FLAGS));
        check($sformatf("v%0d_ovf", i), 64'(v32), 64'(vecs[i].v & FLAGS));
    endtask

    initial begin
        //           a             b             op       result        z     c     v
        vecs[0]  = '{32'd5,        32'd3,        4'b0010, 32'd8,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'd1,        4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'h80000000, 32'd1,        4'b0111, 32'd1,        1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32'd7,        32'd7,        4'b0110, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd0,        4'b0111, 32'd1,        1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'd5,        32'd3,        4'b0111, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'd0,        32'h12345678, 4'b1000, 32'h12345678, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'd0,        32'd0,        4'b1100, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 4'b0010, 32'd0,        1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
        in_valid8  = 1'b0; out_ready8  = 1'b1; a8  = '0; b8  = '0; op8  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_result", 64'(res32), 64'd0);
        check("rst_flags", 64'({z32, c32, v32}), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd1);
        check("rst8_out_valid", 64'(out_valid8), 64'd0);

        for (int i = 0; i < 11; i++) run_vec(i);
        tick();

        // Eight back-to-back operations, consumer always ready
        out_ready32 = 1'b1;
        op32 = 4'b0010;
        b32  = 32'd100;
        for (int c = 0; c < 10; c++) begin
            in_valid32 = (c < 8);
            a32 = 32'(c + 10);
            tick();
            check($sformatf("stream%0d_valid", c), 64'(out_valid32), 64'((c >= 1) && (c <= 8)));
            if (c >= 1 && c <= 8)
                check($sformatf("stream%0d_result", c), 64'(res32), 64'(c + 109));
        end

        // Backpressure: two accepts fill the pipe, then in_ready drops; result holds
        out_ready32 = 1'b0;
        in_valid32  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a32 = 32'(200 + k);
            check($sformatf("bp%0d_in_ready", k), 64'(in_ready32), 64'(k < 2));
            tick();
            check($sformatf("bp%0d_valid", k), 64'(out_valid32), 64'(k >= 1));
            if (k >= 1) check($sformatf("bp%0d_hold", k), 64'(res32), 64'd300);
        end
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        tick();
        check("bp_drain_valid", 64'(out_valid32), 64'd1);
        check("bp_drain_result", 64'(res32), 64'd301);
        tick();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Reset with two operations in flight; input during reset is ignored
        out_ready32 = 1'b0;
        in_valid32 = 1'b1; op32 = 4'b0010; a32 = 32'd1; b32 = 32'd1;
        tick();
        a32 = 32'd2;
        tick();
        check("pre_rst_valid", 64'(out_valid32), 64'd1);
        reset = 1'b1;
        a32 = 32'd3;
        tick();
        reset = 1'b0;
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
        check("mid_rst_valid", 64'(out_valid32), 64'd0);
        check("mid_rst_result", 64'(res32), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready32), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst%0d_valid", k), 64'(out_valid32), 64'd0);
        end
        run_vec(0);

        // WIDTH=8 instance
        in_valid8 = 1'b1; a8 = 8'd5; b8 = 8'd3; op8 = 4'b0010;
        tick();
        in_valid8 = 1'b0;
        check("w8_lat1_valid", 64'(out_valid8), 64'd0);
        tick();
        check("w8_valid", 64'(out_valid8), 64'd1);
        check("w8_result", 64'(res8), 64'd8);
        check("w8_flags", 64'({z8, c8, v8}), 64'd0);
        in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'd1; op8 = 4'b0010;
        tick();
        in_valid8 = 1'b0;
        tick();
        check("w8_ovf_result", 64'(res8), 64'h80);
        check("w8_ovf_flag", 64'(v8), 64'(FLAGS));
        check("w8_ovf_cout", 64'(c8), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
